// File: rtl/calendar_pkg.sv
// Shared state/field codes for the clock/calendar sequencer.
package calendar_pkg;

    localparam int unsigned FIELD_W    = 3;
    localparam int unsigned NUM_FIELDS = 6;

    // State code doubles as the selected-field code shown on o_set_field.
    typedef enum logic [FIELD_W-1:0] {
        RUN       = 3'd0,
        SET_SEC   = 3'd1,
        SET_MIN   = 3'd2,
        SET_HOUR  = 3'd3,
        SET_DAY   = 3'd4,
        SET_MONTH = 3'd5,
        SET_YEAR  = 3'd6
    } state_e;

    // Bit positions within the increment-pulse bundle.
    localparam int unsigned FIELD_SEC   = 0;
    localparam int unsigned FIELD_MIN   = 1;
    localparam int unsigned FIELD_HOUR  = 2;
    localparam int unsigned FIELD_DAY   = 3;
    localparam int unsigned FIELD_MONTH = 4;
    localparam int unsigned FIELD_YEAR  = 5;

endpackage

// File: rtl/btn_edge.sv
// Button synchronizer followed by a rising-edge detector; one event per press.
module btn_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_evt
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_btn};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Event is combinational so the top can register it without extra latency.
    assign o_evt = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/calendar_ctrl.sv
// Calendar sequencer: 1 Hz tick prescaler, RUN/SET field-select FSM and
// registered increment / carry-enable / blink outputs.
module calendar_ctrl
    import calendar_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 50_000_000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_btn_mode,
    input  logic         i_btn_inc,
    output logic         o_inc_sec,
    output logic         o_inc_min,
    output logic         o_inc_hour,
    output logic         o_inc_day,
    output logic         o_inc_month,
    output logic         o_inc_year,
    output logic [2:0]   o_set_field,
    output logic         o_carry_en,
    output logic         o_blink
);

    localparam int unsigned      CNT_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(TICK_DIV / 2);

    state_e                  state_q, state_n;
    logic [CNT_W-1:0]        pre_q, pre_n;
    logic [NUM_FIELDS-1:0]   inc_q, inc_n;
    logic                    carry_q, carry_n;
    logic                    blink_q, blink_n;
    logic                    mode_evt, inc_evt;

    btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_mode (
        .clk   (clk),
        .rst_n (rst_n),
        .i_btn (i_btn_mode),
        .o_evt (mode_evt)
    );

    btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_inc (
        .clk   (clk),
        .rst_n (rst_n),
        .i_btn (i_btn_inc),
        .o_evt (inc_evt)
    );

    // State, prescaler and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            pre_q   <= '0;
            inc_q   <= '0;
            carry_q <= 1'b1;
            blink_q <= 1'b0;
        end else begin
            state_q <= state_n;
            pre_q   <= pre_n;
            inc_q   <= inc_n;
            carry_q <= carry_n;
            blink_q <= blink_n;
        end
    end

    // Next state and next registered outputs; MODE has priority over INC.
    always_comb begin
        state_n = state_q;
        pre_n   = (pre_q == CNT_MAX) ? '0 : pre_q + CNT_W'(1);
        inc_n   = '0;

        if (mode_evt) begin
            case (state_q)
                RUN:       state_n = SET_SEC;
                SET_SEC:   state_n = SET_MIN;
                SET_MIN:   state_n = SET_HOUR;
                SET_HOUR:  state_n = SET_DAY;
                SET_DAY:   state_n = SET_MONTH;
                SET_MONTH: state_n = SET_YEAR;
                SET_YEAR: begin
                    state_n = RUN;
                    pre_n   = '0;
                end
                default:   state_n = RUN;
            endcase
        end else if (inc_evt) begin
            case (state_q)
                SET_SEC:   inc_n[FIELD_SEC]   = 1'b1;
                SET_MIN:   inc_n[FIELD_MIN]   = 1'b1;
                SET_HOUR:  inc_n[FIELD_HOUR]  = 1'b1;
                SET_DAY:   inc_n[FIELD_DAY]   = 1'b1;
                SET_MONTH: inc_n[FIELD_MONTH] = 1'b1;
                SET_YEAR:  inc_n[FIELD_YEAR]  = 1'b1;
                default:   inc_n = '0;
            endcase
        end

        // Tick only while staying in RUN, so no seconds pulse accompanies entry to SET.
        if ((state_q == RUN) && !mode_evt && (pre_q == CNT_MAX)) begin
            inc_n[FIELD_SEC] = 1'b1;
        end

        carry_n = (state_n == RUN);
        blink_n = (state_n != RUN) && (pre_n < CNT_HALF);
    end

    assign o_inc_sec   = inc_q[FIELD_SEC];
    assign o_inc_min   = inc_q[FIELD_MIN];
    assign o_inc_hour  = inc_q[FIELD_HOUR];
    assign o_inc_day   = inc_q[FIELD_DAY];
    assign o_inc_month = inc_q[FIELD_MONTH];
    assign o_inc_year  = inc_q[FIELD_YEAR];
    assign o_set_field = state_q;
    assign o_carry_en  = carry_q;
    assign o_blink     = blink_q;

endmodule

// File: tb/tb_calendar_ctrl.sv
// Scoreboard bench for calendar_ctrl with TICK_DIV=4, SYNC_STAGES=2.
module tb_calendar_ctrl;

    localparam logic [5:0] P_SEC  = 6'b000001;
    localparam logic [5:0] P_HOUR = 6'b000100;
    localparam logic [5:0] P_MON  = 6'b010000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic       inc_sec, inc_min, inc_hour, inc_day, inc_month, inc_year;
    logic [2:0] set_field;
    logic       carry_en, blink;
    logic [5:0] inc_vec;
    int         cyc;
    int         errors = 0;
    int         checks = 0;

    typedef struct { int cyc; logic [5:0] vec; } pulse_t;
    typedef struct { int cyc; logic [2:0] fld; } field_t;
    pulse_t pulse_q[$];
    field_t field_q[$];

    calendar_ctrl #(.TICK_DIV(4), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_btn_mode  (btn_mode),
        .i_btn_inc   (btn_inc),
        .o_inc_sec   (inc_sec),
        .o_inc_min   (inc_min),
        .o_inc_hour  (inc_hour),
        .o_inc_day   (inc_day),
        .o_inc_month (inc_month),
        .o_inc_year  (inc_year),
        .o_set_field (set_field),
        .o_carry_en  (carry_en),
        .o_blink     (blink)
    );

    assign inc_vec = {inc_year, inc_month, inc_day, inc_hour, inc_min, inc_sec};

    always #5 clk = ~clk;

    // Edge count since reset release: cyc == k right after edge k.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic ep(input int c, input logic [5:0] v);
        pulse_t p;
        p.cyc = c;
        p.vec = v;
        pulse_q.push_back(p);
    endtask

    task automatic ef(input int c, input logic [2:0] f);
        field_t e;
        e.cyc = c;
        e.fld = f;
        field_q.push_back(e);
    endtask

    task automatic goto(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic press(input int c, input logic m, input logic i);
        goto(c);
        btn_mode = m;
        btn_inc  = i;
        goto(c + 3);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
    endtask

    // Monitor: compares every pulse and every field change against the queues.
    initial begin
        logic [2:0] last_fld;
        pulse_t     p;
        field_t     f;
        last_fld = 3'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last_fld = 3'd0;
            end else begin
                chk("carry_vs_field", int'(carry_en), (set_field == 3'd0) ? 1 : 0);
                if (inc_vec != 6'd0) begin
                    if (pulse_q.size() == 0) begin
                        chk("pulse_extra", int'(inc_vec), 0);
                    end else begin
                        p = pulse_q.pop_front();
                        chk("pulse_cyc", cyc, p.cyc);
                        chk("pulse_vec", int'(inc_vec), int'(p.vec));
                    end
                end
                if (set_field != last_fld) begin
                    if (field_q.size() == 0) begin
                        chk("field_extra", int'(set_field), int'(last_fld));
                    end else begin
                        f = field_q.pop_front();
                        chk("field_cyc", cyc, f.cyc);
                        chk("field_val", int'(set_field), int'(f.fld));
                    end
                    last_fld = set_field;
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: no finish by time %0t", $time);
        $fatal(1);
    end

    initial begin
        // Reset state
        #12;
        chk("rst_field", int'(set_field), 0);
        chk("rst_carry", int'(carry_en), 1);
        chk("rst_blink", int'(blink), 0);
        chk("rst_inc",   int'(inc_vec), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: free-running ticks in RUN
        ep(4, P_SEC); ep(8, P_SEC); ep(12, P_SEC); ep(16, P_SEC); ep(20, P_SEC);
        goto(2);
        chk("run_field", int'(set_field), 0);
        chk("run_carry", int'(carry_en), 1);
        chk("run_blink", int'(blink), 0);
        goto(10);
        chk("run_blink2", int'(blink), 0);

        // 2: walk all fields back to RUN; prescaler cleared at edge 59
        ef(23, 3'd1); ef(29, 3'd2); ef(35, 3'd3); ef(41, 3'd4);
        ef(47, 3'd5); ef(53, 3'd6); ef(59, 3'd0);
        ep(63, P_SEC);
        for (int p = 0; p < 7; p++) press(20 + 6 * p, 1'b1, 1'b0);

        // Advance to field 5
        ef(64, 3'd1); ef(70, 3'd2); ef(76, 3'd3); ef(82, 3'd4); ef(88, 3'd5);
        for (int p = 0; p < 5; p++) press(61 + 6 * p, 1'b1, 1'b0);
        goto(88);
        chk("set_carry", int'(carry_en), 0);
        chk("blink_on",  int'(blink), 1);
        goto(89);
        chk("blink_off", int'(blink), 0);

        // 3: three INC presses in field 5
        ep(92, P_MON); ep(98, P_MON); ep(104, P_MON);
        for (int p = 0; p < 3; p++) press(89 + 6 * p, 1'b0, 1'b1);

        // Through RUN (clear at 116, tick at 120) to field 1
        ef(110, 3'd6); ef(116, 3'd0); ep(120, P_SEC); ef(122, 3'd1);
        press(107, 1'b1, 1'b0);
        press(113, 1'b1, 1'b0);
        press(119, 1'b1, 1'b0);

        // 4: MODE and INC together in field 1
        ef(128, 3'd2);
        press(125, 1'b1, 1'b1);

        // 5: INC held 50 cycles in field 3
        ef(134, 3'd3);
        press(131, 1'b1, 1'b0);
        ep(140, P_HOUR);
        goto(137);
        btn_inc = 1'b1;
        goto(187);
        btn_inc = 1'b0;

        // 6: async reset in field 3
        goto(190);
        chk("pre_rst_field", int'(set_field), 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_field", int'(set_field), 0);
        chk("arst_carry", int'(carry_en), 1);
        chk("arst_blink", int'(blink), 0);
        chk("arst_inc",   int'(inc_vec), 0);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        ep(4, P_SEC); ep(8, P_SEC);
        goto(10);

        chk("pulse_q_left", pulse_q.size(), 0);
        chk("field_q_left", field_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
